spi_bus_arbiter: RTL and testbench

- Shares one spi_master instance between NUM_REQ requesters, e.g. the mode-config sequencer and a telemetry readout.
- Grants the bus round-robin and owns SS for the whole transaction.
- Feeds bytes to spi_master through its start/busy handshake and routes each received byte back to the granted requester.
- Sits between the requesters and spi_master, in the CLK_26 domain.

---
 rtl/spi_arb_pkg.sv | 26 ++
 rtl/spi_bus_arbiter_rr_arbiter.sv | 29 ++
 rtl/spi_bus_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM states, default timing
// constants and the counter width helper.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_START    = 3'd3,
    ST_WAIT_HI  = 3'd4,
    ST_WAIT_LO  = 3'd5,
    ST_HOLD     = 3'd6,
    ST_GAP      = 3'd7
  } arb_state_e;

  localparam int DEF_SETUP_CYC   = 4;
  localparam int DEF_HOLD_CYC    = 4;
  localparam int DEF_GAP_CYC     = 2;
  localparam int DEF_TIMEOUT_CYC = 1023;

  // Bits needed to hold any value 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan ptr+1 .. ptr+NUM_REQ so the last winner has lowest priority.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!valid && req[(int'(ptr) + i) % NUM_REQ]) begin
        valid = 1'b1;
        gnt[(int'(ptr) + i) % NUM_REQ] = 1'b1;
        idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of a shared spi_master: grants one requester per
// transaction, drives SS and the start/busy byte handshake, routes rx bytes.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int LEN_W       = 4,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]     req_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       byte_ack,
  output logic [7:0]               rx_data,
  output logic [NUM_REQ-1:0]       rx_valid,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       error,
  output logic                     spi_start,
  output logic [7:0]               spi_data_in,
  input  logic                     spi_busy,
  input  logic                     spi_chip_rdy,
  input  logic [7:0]               spi_data_out,
  output logic                     ss
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYC > SETUP_CYC) ?
                           ((TIMEOUT_CYC > HOLD_CYC) ? TIMEOUT_CYC : HOLD_CYC) :
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC);
  localparam int CNT_W   = cnt_w((CNT_MAX > GAP_CYC) ? CNT_MAX : GAP_CYC);

  // SETUP and HOLD are measured SS-edge to start / busy-fall to SS-edge, so
  // the state itself lasts one cycle less (the neighbouring decision cycle
  // makes up the rest). SETUP_CYC and HOLD_CYC must be at least 2.
  localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SETUP_CYC - 2);
  localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(HOLD_CYC - 2);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_END    = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   byte_ack_q, byte_ack_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic [NUM_REQ-1:0]   rx_valid_q, rx_valid_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   error_q, error_d;
  logic                 spi_start_q, spi_start_d;
  logic [7:0]           spi_data_q, spi_data_d;
  logic                 ss_q, ss_d;

  logic [NUM_REQ-1:0]   arb_gnt_s;
  logic [IDX_W-1:0]     arb_idx_s;
  logic                 arb_valid_s;
  logic [LEN_W-1:0]     win_len_s;
  logic [NUM_REQ-1:0]   win_oh_s;
  logic                 abort_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  assign win_len_s = req_len[int'(arb_idx_s) * LEN_W +: LEN_W];
  assign win_oh_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    rem_d       = rem_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    byte_ack_d  = '0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = '0;
    done_d      = '0;
    error_d     = '0;
    spi_start_d = 1'b0;
    spi_data_d  = spi_data_q;
    ss_d        = ss_q;
    abort_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          idx_d = arb_idx_s;
          ptr_d = arb_idx_s;
          rem_d = win_len_s;
          if (win_len_s == '0) begin
            done_d  = arb_gnt_s;
            state_d = ST_GAP;
          end else begin
            grant_d = arb_gnt_s;
            ss_d    = 1'b0;
            state_d = ST_SETUP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_END) state_d = ST_WAIT_RDY;
        else                    state_d = ST_SETUP;
      end
      ST_WAIT_RDY: begin
        // Start, ack and tx byte register together so they appear in START.
        if (spi_chip_rdy && !spi_busy) begin
          spi_start_d = 1'b1;
          byte_ack_d  = win_oh_s;
          spi_data_d  = req_data[int'(idx_q) * 8 +: 8];
          state_d     = ST_START;
        end else if (cnt_q == TO_END) begin
          abort_s = 1'b1;
        end else begin
          state_d = ST_WAIT_RDY;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (spi_busy)               state_d = ST_WAIT_LO;
        else if (cnt_q == TO_END)   abort_s = 1'b1;
        else                        state_d = ST_WAIT_HI;
      end
      ST_WAIT_LO: begin
        if (!spi_busy) begin
          rx_data_d  = spi_data_out;
          rx_valid_d = win_oh_s;
          rem_d      = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_HOLD;
          else                    state_d = ST_WAIT_RDY;
        end else if (cnt_q == TO_END) begin
          abort_s = 1'b1;
        end else begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_END) begin
          ss_d    = 1'b1;
          done_d  = win_oh_s;
          grant_d = '0;
          state_d = ST_GAP;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_END) state_d = ST_IDLE;
        else                  state_d = ST_GAP;
      end
      default: begin
        ss_d    = 1'b1;
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (abort_s) begin
      ss_d    = 1'b1;
      done_d  = win_oh_s;
      error_d = win_oh_s;
      grant_d = '0;
      state_d = ST_GAP;
    end else begin
      abort_s = 1'b0;
    end

    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = cnt_d;
  end

  // State and output registers; ptr resets to the last requester so 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      grant_q     <= '0;
      byte_ack_q  <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= '0;
      done_q      <= '0;
      error_q     <= '0;
      spi_start_q <= 1'b0;
      spi_data_q  <= 8'h00;
      ss_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      byte_ack_q  <= byte_ack_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      error_q     <= error_d;
      spi_start_q <= spi_start_d;
      spi_data_q  <= spi_data_d;
      ss_q        <= ss_d;
    end
  end

  assign grant       = grant_q;
  assign byte_ack    = byte_ack_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign done        = done_q;
  assign error       = error_q;
  assign spi_start   = spi_start_q;
  assign spi_data_in = spi_data_q;
  assign ss          = ss_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a behavioural spi_master and requesters.
module tb_spi_bus_arbiter;

  localparam int NR = 2;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR*LW-1:0] req_len = '0;
  logic [NR*8-1:0]  req_data;
  logic [NR-1:0] grant, byte_ack, rx_valid, done, error;
  logic [7:0]    rx_data, spi_data_in;
  logic          spi_start, ss;
  logic          spi_busy = 1'b0;
  logic          spi_chip_rdy = 1'b1;
  logic [7:0]    spi_data_out = 8'h00;

  spi_bus_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_data(req_data),
    .grant(grant), .byte_ack(byte_ack), .rx_data(rx_data), .rx_valid(rx_valid),
    .done(done), .error(error), .spi_start(spi_start), .spi_data_in(spi_data_in),
    .spi_busy(spi_busy), .spi_chip_rdy(spi_chip_rdy), .spi_data_out(spi_data_out),
    .ss(ss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_mem [2][16];
  logic [7:0] resp_mem [16];
  logic [3:0] byte_ptr [2];
  int  resp_i = 0;
  logic rdy_en = 1'b1;

  assign req_data = {tx_mem[1][byte_ptr[1]], tx_mem[0][byte_ptr[0]]};

  logic [7:0] start_data[$];
  logic [7:0] rx_bytes[$];
  int rx_idx[$], done_idx[$], done_err[$], done_ss[$], done_cyc[$], grant_idx[$], start_cyc[$];
  int cyc = 0, ss_low_cnt = 0, ss_high_run = 0, min_gap = 1000;
  int ss_fall_cyc = 0, ss_rise_cyc = 0, busy_fall_cyc = 0;
  int start_wide = 0, grant_multi = 0, err_alone = 0;
  logic prev_start = 1'b0, prev_gany = 1'b0, prev_ss = 1'b1, prev_busy = 1'b0;

  function automatic int oh2i(input logic [1:0] v);
    return v[1] ? 1 : 0;
  endfunction

  // spi_master model: busy rises the cycle after start, lasts 3 cycles, then returns a byte.
  initial begin
    int bcnt;
    logic pend;
    bcnt = 0;
    pend = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        spi_busy = 1'b0; pend = 1'b0; bcnt = 0;
      end else begin
        if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) begin
            spi_busy = 1'b0;
            spi_data_out = resp_mem[resp_i % 16];
            resp_i++;
          end
        end else if (pend) begin
          spi_busy = 1'b1; bcnt = 3; pend = 1'b0;
        end
        if (spi_start) pend = 1'b1;
        if (|byte_ack) byte_ptr[oh2i(byte_ack)] = byte_ptr[oh2i(byte_ack)] + 4'd1;
      end
      spi_chip_rdy = rdy_en && !spi_busy;
    end
  end

  // Event monitor sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (spi_start) begin
        start_data.push_back(spi_data_in); start_cyc.push_back(cyc);
        if (prev_start) start_wide++;
      end
      if (|rx_valid) begin rx_bytes.push_back(rx_data); rx_idx.push_back(oh2i(rx_valid)); end
      if (|done) begin
        done_idx.push_back(oh2i(done)); done_err.push_back(int'(|(error & done)));
        done_ss.push_back(int'(ss)); done_cyc.push_back(cyc);
      end
      if ((error & ~done) != 2'b00) err_alone++;
      if ((grant != 2'b00) && !prev_gany) grant_idx.push_back(oh2i(grant));
      if (grant == 2'b11) grant_multi++;
      if (!ss) ss_low_cnt++;
      if (!ss && prev_ss && ss_high_run < min_gap) min_gap = ss_high_run;
      if (!ss && prev_ss) ss_fall_cyc = cyc;
      if (ss && !prev_ss) ss_rise_cyc = cyc;
      if (ss) ss_high_run++;
      else    ss_high_run = 0;
      if (!spi_busy && prev_busy) busy_fall_cyc = cyc;
      prev_start = spi_start; prev_gany = |grant; prev_ss = ss; prev_busy = spi_busy;
    end
  end

  task automatic tick();
    @(negedge clk); #2;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return done_idx.size();
      1:       return start_data.size();
      2:       return rx_bytes.size();
      default: return 0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (qsize(which) < n && k < budget) begin tick(); k++; end
    if (qsize(which) < n) begin
      checks++; failures++;
      $display("FAIL %s timeout: got %0d events, wanted %0d", nm, qsize(which), n);
    end
  endtask

  task automatic clear_logs();
    start_data.delete(); rx_bytes.delete(); rx_idx.delete(); done_idx.delete();
    done_err.delete(); done_ss.delete(); done_cyc.delete(); grant_idx.delete(); start_cyc.delete();
    ss_low_cnt = 0; resp_i = 0; byte_ptr[0] = 4'd0; byte_ptr[1] = 4'd0;
  endtask

  task automatic run_txn(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1);
    clear_logs();
    req_len = {l1, l0};
    req = r;
    wait_for(0, 1, 2000, "txn_done");
    req = 2'b00;
    repeat (5) tick();
  endtask

  task automatic check_txn(input string nm, input int w, input int nb);
    chk({nm, "_done_cnt"}, done_idx.size(), 1);
    if (done_idx.size() > 0) begin
      chk({nm, "_done_idx"}, done_idx[0], w);
      chk({nm, "_done_err"}, done_err[0], 0);
      chk({nm, "_done_ss"}, done_ss[0], 1);
    end
    chk({nm, "_starts"}, start_data.size(), nb);
    chk({nm, "_rx_cnt"}, rx_bytes.size(), nb);
    for (int k = 0; k < nb && k < start_data.size(); k++)
      chk({nm, "_tx_byte"}, start_data[k], tx_mem[w][k]);
    for (int k = 0; k < rx_bytes.size(); k++) begin
      chk({nm, "_rx_byte"}, rx_bytes[k], resp_mem[k]);
      chk({nm, "_rx_idx"}, rx_idx[k], w);
    end
    chk({nm, "_grants"}, grant_idx.size(), (nb > 0) ? 1 : 0);
    if (grant_idx.size() > 0) chk({nm, "_grant_idx"}, grant_idx[0], w);
    if (nb == 0) chk({nm, "_ss_low"}, ss_low_cnt, 0);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    int         exp_win;
    int         exp_bytes;
  } vec_t;

  vec_t tab [7];

  initial begin
    tab[0] = '{req: 2'b11, len0: 4'd1,  len1: 4'd1, exp_win: 1, exp_bytes: 1};
    tab[1] = '{req: 2'b11, len0: 4'd1,  len1: 4'd1, exp_win: 0, exp_bytes: 1};
    tab[2] = '{req: 2'b10, len0: 4'd1,  len1: 4'd3, exp_win: 1, exp_bytes: 3};
    tab[3] = '{req: 2'b10, len0: 4'd1,  len1: 4'd0, exp_win: 1, exp_bytes: 0};
    tab[4] = '{req: 2'b11, len0: 4'd2,  len1: 4'd1, exp_win: 0, exp_bytes: 2};
    tab[5] = '{req: 2'b01, len0: 4'd15, len1: 4'd1, exp_win: 0, exp_bytes: 15};
    tab[6] = '{req: 2'b11, len0: 4'd1,  len1: 4'd1, exp_win: 1, exp_bytes: 1};

    for (int k = 0; k < 16; k++) begin
      tx_mem[0][k] = 8'h40 + 8'(k);
      tx_mem[1][k] = 8'hC0 + 8'(k);
      resp_mem[k]  = 8'((k + 1) * 17);
    end
    tx_mem[0][0] = 8'hA5;
    tx_mem[0][1] = 8'h3C;
    byte_ptr[0] = 4'd0;
    byte_ptr[1] = 4'd0;

    // Reset values
    repeat (3) tick();
    chk("rst_ss", ss, 1);
    chk("rst_grant", grant, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_done", done, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_data_in", spi_data_in, 0);
    rst = 1'b1;
    repeat (3) tick();

    // Test 1: single 2-byte transaction with timing
    run_txn(2'b01, 4'd2, 4'd0);
    check_txn("t1", 0, 2);
    if (start_data.size() == 2) begin
      chk("t1_tx0", start_data[0], 8'hA5);
      chk("t1_tx1", start_data[1], 8'h3C);
      chk("t1_setup_cyc", start_cyc[0] - ss_fall_cyc, 4);
    end
    if (rx_bytes.size() == 2) begin
      chk("t1_rx0", rx_bytes[0], 8'h11);
      chk("t1_rx1", rx_bytes[1], 8'h22);
    end
    chk("t1_hold_cyc", ss_rise_cyc - busy_fall_cyc, 4);
    if (done_cyc.size() > 0) chk("t1_done_at_ss_rise", done_cyc[0], ss_rise_cyc);

    // Table of single transactions (covers zero length and max length)
    for (int v = 0; v < 7; v++) begin
      run_txn(tab[v].req, tab[v].len0, tab[v].len1);
      check_txn($sformatf("vec%0d", v), tab[v].exp_win, tab[v].exp_bytes);
    end

    // Test 2: both requesting continuously, four back-to-back transactions
    clear_logs();
    min_gap = 1000;
    req_len = {4'd1, 4'd1};
    req = 2'b11;
    wait_for(0, 4, 3000, "t2_done");
    req = 2'b00;
    repeat (5) tick();
    chk("t2_grant_cnt", grant_idx.size(), 4);
    for (int k = 0; k < 4 && k < grant_idx.size(); k++)
      chk($sformatf("t2_grant_order%0d", k), grant_idx[k], k % 2);
    chk("t2_min_gap_ok", int'(min_gap >= 2), 1);
    chk("t2_starts", start_data.size(), 4);

    // Test 4: chip_rdy stuck low -> timeout abort, then re-arbitration
    clear_logs();
    rdy_en = 1'b0;
    req_len = {4'd1, 4'd1};
    req = 2'b01;
    wait_for(0, 1, 2000, "t4_abort");
    rdy_en = 1'b1;
    if (done_idx.size() > 0) begin
      chk("t4_done_idx", done_idx[0], 0);
      chk("t4_err", done_err[0], 1);
      chk("t4_ss", done_ss[0], 1);
    end
    chk("t4_no_start", start_data.size(), 0);
    chk("t4_ss_low_range", int'(ss_low_cnt >= 1023 && ss_low_cnt <= 1029), 1);
    wait_for(0, 2, 200, "t4_rearb");
    req = 2'b00;
    repeat (5) tick();
    if (done_idx.size() > 1) begin
      chk("t4_rearb_idx", done_idx[1], 0);
      chk("t4_rearb_err", done_err[1], 0);
    end
    chk("t4_rearb_starts", start_data.size(), 1);

    // Test 6: req dropped after the first byte, transaction still completes
    clear_logs();
    req_len = {4'd1, 4'd3};
    req = 2'b01;
    wait_for(2, 1, 200, "t6_first_rx");
    req = 2'b00;
    wait_for(0, 1, 200, "t6_done");
    repeat (5) tick();
    check_txn("t6", 0, 3);

    // Test 5: async reset during the start of the second byte
    clear_logs();
    req_len = {4'd1, 4'd3};
    req = 2'b01;
    wait_for(1, 2, 200, "t5_second_start");
    chk("t5_start_before", spi_start, 1);
    rst = 1'b0;
    #1;
    chk("t5_ss_async", ss, 1);
    chk("t5_start_async", spi_start, 0);
    chk("t5_grant_async", grant, 0);
    req = 2'b00;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("t5_no_done", done_idx.size(), 0);
    run_txn(2'b11, 4'd1, 4'd1);
    check_txn("t5_after", 0, 1);

    chk("start_width", start_wide, 0);
    chk("grant_onehot", grant_multi, 0);
    chk("error_without_done", err_alone, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
